// File: rtl/uart_link_engine.sv
// Full-duplex UART engine: valid/ready word interfaces on both sides, configurable
// bit period, width, parity and stop bits, with frame/parity/overrun reporting.
module uart_link_engine #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_busy_o,
  output logic                 uart_tx_o,
  input  logic                 uart_rx_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 rx_frame_err_o,
  output logic                 rx_parity_err_o,
  output logic                 rx_overrun_o
);

  localparam int CW = $clog2(2 * CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF      = CW'(CLKS_PER_BIT / 2);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]           r_tx_state;
  logic [CW-1:0]        r_tx_cnt;
  logic [BW-1:0]        r_tx_idx;
  logic [DATA_BITS-1:0] r_tx_shift;
  logic                 r_tx_par;
  logic                 r_tx_line;
  logic                 w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == BIT_LAST);
  assign tx_ready_o   = (r_tx_state == S_IDLE);
  assign tx_busy_o    = ~tx_ready_o;
  assign uart_tx_o    = r_tx_line;

  // The line register is updated one cycle ahead so each bit lasts exactly CLKS_PER_BIT.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_idx   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx_line  <= 1'b1;
    end else begin
      case (r_tx_state)
        S_IDLE: begin
          if (tx_valid_i) begin
            r_tx_shift <= tx_data_i;
            r_tx_par   <= (PARITY == 1) ? ~^tx_data_i : ^tx_data_i;
            r_tx_line  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_state <= S_START;
          end
        end
        S_START: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_idx   <= '0;
            r_tx_line  <= r_tx_shift[0];
            r_tx_state <= S_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            r_tx_cnt <= '0;
            if (r_tx_idx == DATA_LAST) begin
              if (PARITY != 0) begin
                r_tx_line  <= r_tx_par;
                r_tx_state <= S_PAR;
              end else begin
                r_tx_line  <= 1'b1;
                r_tx_state <= S_STOP;
              end
            end else begin
              r_tx_idx   <= r_tx_idx + 1'b1;
              r_tx_shift <= {1'b0, r_tx_shift[DATA_BITS-1:1]};
              r_tx_line  <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (w_tx_bit_end) begin
            r_tx_cnt   <= '0;
            r_tx_line  <= 1'b1;
            r_tx_state <= S_STOP;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (r_tx_cnt == STOP_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_state <= S_IDLE;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: r_tx_state <= S_IDLE;
      endcase
    end
  end

  logic                 r_rx_meta;
  logic                 r_rx_sync;
  logic                 r_rx_prev;
  logic [2:0]           r_rx_state;
  logic [CW-1:0]        r_rx_cnt;
  logic [BW-1:0]        r_rx_idx;
  logic [DATA_BITS-1:0] r_rx_shift;
  logic                 r_rx_par_stage;
  logic                 r_rx_frm_stage;
  logic                 r_rx_commit;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid;
  logic                 r_rx_frame_err;
  logic                 r_rx_parity_err;
  logic                 r_rx_overrun;
  logic                 w_rx_fall;
  logic                 w_rx_bit_end;
  logic                 w_rx_hs;

  // Requiring a high previous sample means a held-low (break) line never restarts reception.
  assign w_rx_fall    = r_rx_prev & ~r_rx_sync;
  assign w_rx_bit_end = (r_rx_cnt == BIT_LAST);
  assign w_rx_hs      = r_rx_valid & rx_ready_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_meta      <= 1'b1;
      r_rx_sync      <= 1'b1;
      r_rx_prev      <= 1'b1;
      r_rx_state     <= S_IDLE;
      r_rx_cnt       <= '0;
      r_rx_idx       <= '0;
      r_rx_shift     <= '0;
      r_rx_par_stage <= 1'b0;
      r_rx_frm_stage <= 1'b0;
      r_rx_commit    <= 1'b0;
    end else begin
      r_rx_meta   <= uart_rx_i;
      r_rx_sync   <= r_rx_meta;
      r_rx_prev   <= r_rx_sync;
      r_rx_commit <= 1'b0;
      case (r_rx_state)
        S_IDLE: begin
          if (w_rx_fall) begin
            r_rx_cnt   <= CW'(1);
            r_rx_state <= S_START;
          end
        end
        S_START: begin
          if (r_rx_cnt == HALF) begin
            r_rx_cnt       <= '0;
            r_rx_idx       <= '0;
            r_rx_par_stage <= 1'b0;
            r_rx_state     <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_rx_bit_end) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
            if (r_rx_idx == DATA_LAST) begin
              r_rx_state <= (PARITY != 0) ? S_PAR : S_STOP;
            end else begin
              r_rx_idx <= r_rx_idx + 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (w_rx_bit_end) begin
            r_rx_cnt       <= '0;
            r_rx_par_stage <= (PARITY == 1) ? ~^{r_rx_shift, r_rx_sync} : ^{r_rx_shift, r_rx_sync};
            r_rx_state     <= S_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_rx_bit_end) begin
            r_rx_cnt       <= '0;
            r_rx_frm_stage <= ~r_rx_sync;
            r_rx_commit    <= 1'b1;
            r_rx_state     <= S_IDLE;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= S_IDLE;
      endcase
    end
  end

  // A commit coinciding with a handshake loads the new word instead of overrunning.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rx_data       <= '0;
      r_rx_valid      <= 1'b0;
      r_rx_frame_err  <= 1'b0;
      r_rx_parity_err <= 1'b0;
      r_rx_overrun    <= 1'b0;
    end else begin
      if (r_rx_commit && (!r_rx_valid || w_rx_hs)) begin
        r_rx_data       <= r_rx_shift;
        r_rx_frame_err  <= r_rx_frm_stage;
        r_rx_parity_err <= r_rx_par_stage;
        r_rx_valid      <= 1'b1;
      end else if (w_rx_hs) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_hs) begin
        r_rx_overrun <= 1'b0;
      end else if (r_rx_commit && r_rx_valid) begin
        r_rx_overrun <= 1'b1;
      end
    end
  end

  assign rx_data_o       = r_rx_data;
  assign rx_valid_o      = r_rx_valid;
  assign rx_frame_err_o  = r_rx_frame_err;
  assign rx_parity_err_o = r_rx_parity_err;
  assign rx_overrun_o    = r_rx_overrun;

endmodule

// File: tb/tb_uart_link_engine.sv
// Bench for uart_link_engine: three instances (no parity, even/2 stops, odd) driven with
// fixed and random words, checked against a frame-level model of the serial protocol.
module tb_uart_link_engine;

  localparam int CPB = 4;
  localparam int DB  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] a_tx_data, b_tx_data, c_tx_data;
  logic a_tx_valid, b_tx_valid, c_tx_valid;
  logic a_tx_ready, b_tx_ready, c_tx_ready;
  logic a_tx_busy, b_tx_busy, c_tx_busy;
  logic a_uart_tx, b_uart_tx, c_uart_tx;
  logic a_loop, rx_drv_a, rx_drv_b;
  logic a_rx_line, b_rx_line, c_rx_line;
  logic [7:0] a_rx_data, b_rx_data, c_rx_data;
  logic a_rx_valid, b_rx_valid, c_rx_valid;
  logic a_rx_ready, b_rx_ready, c_rx_ready;
  logic a_frm, b_frm, c_frm, a_par, b_par, c_par, a_ovr, b_ovr, c_ovr;

  assign a_rx_line = a_loop ? a_uart_tx : rx_drv_a;
  assign b_rx_line = rx_drv_b;
  assign c_rx_line = c_uart_tx;

  uart_link_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .STOP_BITS(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(a_tx_data), .tx_valid_i(a_tx_valid),
    .tx_ready_o(a_tx_ready), .tx_busy_o(a_tx_busy), .uart_tx_o(a_uart_tx), .uart_rx_i(a_rx_line),
    .rx_data_o(a_rx_data), .rx_valid_o(a_rx_valid), .rx_ready_i(a_rx_ready),
    .rx_frame_err_o(a_frm), .rx_parity_err_o(a_par), .rx_overrun_o(a_ovr));

  uart_link_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .STOP_BITS(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(b_tx_data), .tx_valid_i(b_tx_valid),
    .tx_ready_o(b_tx_ready), .tx_busy_o(b_tx_busy), .uart_tx_o(b_uart_tx), .uart_rx_i(b_rx_line),
    .rx_data_o(b_rx_data), .rx_valid_o(b_rx_valid), .rx_ready_i(b_rx_ready),
    .rx_frame_err_o(b_frm), .rx_parity_err_o(b_par), .rx_overrun_o(b_ovr));

  uart_link_engine #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(1), .STOP_BITS(1)) u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(c_tx_data), .tx_valid_i(c_tx_valid),
    .tx_ready_o(c_tx_ready), .tx_busy_o(c_tx_busy), .uart_tx_o(c_uart_tx), .uart_rx_i(c_rx_line),
    .rx_data_o(c_rx_data), .rx_valid_o(c_rx_valid), .rx_ready_i(c_rx_ready),
    .rx_frame_err_o(c_frm), .rx_parity_err_o(c_par), .rx_overrun_o(c_ovr));

  typedef struct packed {
    logic [7:0]  d;
    logic        fe;
    logic        pe;
    logic [31:0] t;
  } rx_rec_t;

  rx_rec_t qa[$], qb[$], qc[$];

  // Every completed rx handshake becomes one scoreboard record.
  always @(negedge clk) begin
    if (rst_n && a_rx_valid && a_rx_ready) begin
      qa.push_back('{a_rx_data, a_frm, a_par, cyc});
      $display("[%0d] A rx 0x%02h fe=%0b pe=%0b", cyc, a_rx_data, a_frm, a_par);
    end
    if (rst_n && b_rx_valid && b_rx_ready) begin
      qb.push_back('{b_rx_data, b_frm, b_par, cyc});
      $display("[%0d] B rx 0x%02h fe=%0b pe=%0b", cyc, b_rx_data, b_frm, b_par);
    end
    if (rst_n && c_rx_valid && c_rx_ready) begin
      qc.push_back('{c_rx_data, c_frm, c_par, cyc});
      $display("[%0d] C rx 0x%02h fe=%0b pe=%0b", cyc, c_rx_data, c_frm, c_par);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bits (bit 0 goes first).
  function automatic int nbits(input int pm, input int st);
    return 1 + DB + ((pm != 0) ? 1 : 0) + st;
  endfunction

  function automatic logic [15:0] frame_bits(input logic [7:0] w, input int pm, input int st,
                                             input bit flip, input bit sv);
    logic [15:0] b;
    int k;
    int ones;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DB; i++) b[1+i] = w[i];
    k = 1 + DB;
    ones = $countones(w);
    if (pm != 0) begin
      if (pm == 1) b[k] = ((ones % 2) == 0) ? 1'b1 : 1'b0;
      else         b[k] = ((ones % 2) == 1) ? 1'b1 : 1'b0;
      b[k] = b[k] ^ flip;
      k++;
    end
    for (int s = 0; s < st; s++) begin
      b[k] = (s == 0) ? sv : 1'b1;
      k++;
    end
    return b;
  endfunction

  function automatic logic tx_line(input int which);
    if (which == 0) return a_uart_tx;
    else if (which == 1) return b_uart_tx;
    return c_uart_tx;
  endfunction

  function automatic logic tx_ready(input int which);
    if (which == 0) return a_tx_ready;
    else if (which == 1) return b_tx_ready;
    return c_tx_ready;
  endfunction

  function automatic logic tx_busy(input int which);
    if (which == 0) return a_tx_busy;
    else if (which == 1) return b_tx_busy;
    return c_tx_busy;
  endfunction

  function automatic int q_size(input int which);
    if (which == 0) return qa.size();
    else if (which == 1) return qb.size();
    return qc.size();
  endfunction

  function automatic rx_rec_t get_rec(input int which, input int idx);
    rx_rec_t r;
    r = '0;
    if (idx < q_size(which)) begin
      if (which == 0) r = qa[idx];
      else if (which == 1) r = qb[idx];
      else r = qc[idx];
    end
    return r;
  endfunction

  task automatic set_tx(input int which, input logic [7:0] d, input logic v);
    if (which == 0) begin a_tx_data = d; a_tx_valid = v; end
    else if (which == 1) begin b_tx_data = d; b_tx_valid = v; end
    else begin c_tx_data = d; c_tx_valid = v; end
  endtask

  task automatic set_rx(input int which, input logic v);
    if (which == 0) rx_drv_a = v;
    else rx_drv_b = v;
  endtask

  task automatic wait_q(input int which, input int target, input int budget);
    int t = 0;
    while (q_size(which) < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("rx_count", q_size(which), target);
  endtask

  task automatic send_and_check_tx(input int which, input logic [7:0] w, input int pm, input int st);
    logic [15:0] bits;
    int n, t, errs, low;
    set_tx(which, w, 1'b1);
    t = 0;
    while (!tx_ready(which) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("tx_ready_wait", (t < 500), 1);
    @(negedge clk);
    set_tx(which, w, 1'b0);
    bits = frame_bits(w, pm, st, 1'b0, 1'b1);
    n = nbits(pm, st);
    errs = 0;
    low = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < CPB; c++) begin
        if (tx_line(which) !== bits[b]) errs++;
        if (tx_busy(which) !== ~tx_ready(which)) errs++;
        if (tx_ready(which) === 1'b0) low++;
        @(negedge clk);
      end
    end
    check("tx_wave", errs, 0);
    check("tx_ready_low", low, n * CPB);
    check("tx_ready_back", tx_ready(which), 1);
    $display("[%0d] tx%0d 0x%02h frame of %0d bits", cyc, which, w, n);
  endtask

  task automatic drive_rx(input int which, input logic [7:0] w, input int pm, input int st,
                          input bit flip, input bit sv, input int idle_after);
    logic [15:0] bits;
    bits = frame_bits(w, pm, st, flip, sv);
    for (int b = 0; b < nbits(pm, st); b++) begin
      set_rx(which, bits[b]);
      repeat (CPB) @(negedge clk);
    end
    if (idle_after > 0) begin
      set_rx(which, 1'b1);
      repeat (idle_after) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected $finish before 50000 cycles");
    $fatal(1);
  end

  initial begin
    logic [7:0] ws [0:8];
    logic [7:0] w;
    rx_rec_t r, rp;
    int base, t;
    bit flip, sv;

    rst_n = 1'b0;
    a_loop = 1'b0; rx_drv_a = 1'b1; rx_drv_b = 1'b1;
    set_tx(0, 8'h00, 1'b0); set_tx(1, 8'h00, 1'b0); set_tx(2, 8'h00, 1'b0);
    a_rx_ready = 1'b1; b_rx_ready = 1'b1; c_rx_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_uart_tx", a_uart_tx, 1);
    check("rst_tx_ready", a_tx_ready, 1);
    check("rst_tx_busy", a_tx_busy, 0);
    check("rst_rx_valid", a_rx_valid, 0);
    check("rst_rx_data", a_rx_data, 0);
    check("rst_flags", {a_frm, a_par, a_ovr}, 0);
    check("rst_b_uart_tx", b_uart_tx, 1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xA5 waveform plus random words on the no-parity instance
    send_and_check_tx(0, 8'hA5, 0, 1);
    for (int i = 0; i < 3; i++) send_and_check_tx(0, 8'($urandom), 0, 1);

    // Back-to-back loopback burst; handshake spacing must equal the frame period
    a_loop = 1'b1;
    ws[0] = 8'h00; ws[1] = 8'hFF; ws[2] = 8'h3C;
    for (int i = 3; i < 9; i++) ws[i] = 8'($urandom);
    base = qa.size();
    a_tx_data = ws[0];
    a_tx_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      t = 0;
      while (!a_tx_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      @(negedge clk);
      if (k < 8) a_tx_data = ws[k+1];
      else a_tx_valid = 1'b0;
    end
    wait_q(0, base + 9, 200);
    for (int k = 0; k < 9; k++) begin
      r = get_rec(0, base + k);
      check("loop_data", r.d, ws[k]);
      check("loop_flags", {r.fe, r.pe}, 0);
      if (k > 0) begin
        rp = get_rec(0, base + k - 1);
        check("loop_period", r.t - rp.t, CPB * (1 + DB + 0 + 1) + 1);
      end
    end
    repeat (10) @(negedge clk);
    a_loop = 1'b0;

    // Even parity, two stop bits: bad then good parity on 0x03, then random frames
    base = qb.size();
    drive_rx(1, 8'h03, 2, 2, 1'b1, 1'b1, 4);
    wait_q(1, base + 1, 50);
    r = get_rec(1, base);
    check("even_bad_data", r.d, 8'h03);
    check("even_bad_pe", r.pe, 1);
    drive_rx(1, 8'h03, 2, 2, 1'b0, 1'b1, 4);
    wait_q(1, base + 2, 50);
    r = get_rec(1, base + 1);
    check("even_good_pe", r.pe, 0);
    for (int i = 0; i < 6; i++) begin
      w = 8'($urandom);
      flip = 1'($urandom_range(0, 1));
      sv = 1'($urandom_range(0, 1));
      base = qb.size();
      drive_rx(1, w, 2, 2, flip, sv, 3);
      wait_q(1, base + 1, 50);
      r = get_rec(1, base);
      check("even_rnd_data", r.d, w);
      check("even_rnd_pe", r.pe, flip);
      check("even_rnd_fe", r.fe, !sv);
    end
    send_and_check_tx(1, 8'h03, 2, 2);
    send_and_check_tx(1, 8'($urandom), 2, 2);

    // Odd parity instance in loopback: 0x03 carries parity bit 1
    for (int i = 0; i < 4; i++) begin
      w = (i == 0) ? 8'h03 : 8'($urandom);
      base = qc.size();
      send_and_check_tx(2, w, 1, 1);
      wait_q(2, base + 1, 50);
      r = get_rec(2, base);
      check("odd_loop_data", r.d, w);
      check("odd_loop_flags", {r.fe, r.pe}, 0);
    end

    // Stop bit low followed by a held-low break, then a one-cycle glitch
    base = qa.size();
    drive_rx(0, 8'h5A, 0, 1, 1'b0, 1'b0, 0);
    repeat (20) @(negedge clk);
    rx_drv_a = 1'b1;
    repeat (10) @(negedge clk);
    check("break_count", qa.size(), base + 1);
    r = get_rec(0, base);
    check("frm_data", r.d, 8'h5A);
    check("frm_fe", r.fe, 1);
    rx_drv_a = 1'b0;
    @(negedge clk);
    rx_drv_a = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_count", qa.size(), base + 1);
    check("glitch_valid", a_rx_valid, 0);

    // Overrun: consumer stalled across two frames, then one handshake
    a_rx_ready = 1'b0;
    base = qa.size();
    drive_rx(0, 8'h11, 0, 1, 1'b0, 1'b1, 8);
    check("ovr_first_valid", a_rx_valid, 1);
    check("ovr_first_flag", a_ovr, 0);
    drive_rx(0, 8'h22, 0, 1, 1'b0, 1'b1, 8);
    check("ovr_kept_data", a_rx_data, 8'h11);
    check("ovr_set", a_ovr, 1);
    check("ovr_valid", a_rx_valid, 1);
    a_rx_ready = 1'b1;
    @(negedge clk);
    a_rx_ready = 1'b0;
    check("ovr_hs_count", qa.size(), base + 1);
    r = get_rec(0, base);
    check("ovr_hs_data", r.d, 8'h11);
    check("ovr_cleared", a_ovr, 0);
    check("ovr_valid_drop", a_rx_valid, 0);
    a_rx_ready = 1'b1;
    repeat (4) @(negedge clk);

    // Reset during DATA bit 3 of a loopback frame aborts both directions
    a_loop = 1'b1;
    base = qa.size();
    a_tx_data = 8'($urandom);
    a_tx_valid = 1'b1;
    t = 0;
    while (!a_tx_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    a_tx_valid = 1'b0;
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_uart_tx", a_uart_tx, 1);
    check("mid_rst_tx_ready", a_tx_ready, 1);
    check("mid_rst_tx_busy", a_tx_busy, 0);
    check("mid_rst_rx_valid", a_rx_valid, 0);
    check("mid_rst_rx_data", a_rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    check("mid_rst_no_word", qa.size(), base);
    check("mid_rst_idle_line", a_uart_tx, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
